// File: rtl/mirror_zc_conditioner_pkg.sv
// Shared types and widths for the mirror zero-cross conditioner.
package zc_cond_pkg;

  localparam int PERIOD_W = 24;

  typedef enum logic [1:0] {
    SEARCH  = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10
  } zc_state_e;

endpackage

// File: rtl/mirror_zc_conditioner_period_avg.sv
// Moving-average ring for measured mirror periods: a 2^AVG_LOG2_P entry ring,
// a running sum of all entries and a fill count. Flush clears everything so
// the "oldest" entry subtracted on push is always zero until the ring wraps.
module period_avg
  import zc_cond_pkg::*;
#(
  parameter int AVG_LOG2_P = 2
) (
  input  logic                           clk_i,
  input  logic                           nrst_i,
  input  logic                           push_i,
  input  logic                           flush_i,
  input  logic [PERIOD_W-1:0]            p_i,
  output logic [PERIOD_W+AVG_LOG2_P-1:0] sum_o,
  output logic [AVG_LOG2_P:0]            fill_o,
  output logic                           full_o
);

  localparam int DEPTH  = 1 << AVG_LOG2_P;
  localparam int IDX_W  = (AVG_LOG2_P > 0) ? AVG_LOG2_P : 1;
  localparam int FILL_W = AVG_LOG2_P + 1;
  localparam int SUM_W  = PERIOD_W + AVG_LOG2_P;

  logic [PERIOD_W-1:0] ring_q [DEPTH];
  logic [IDX_W-1:0]    wr_q;
  logic [FILL_W-1:0]   fill_q;
  logic [SUM_W-1:0]    sum_q;

  assign full_o = (fill_q == FILL_W'(DEPTH));
  assign fill_o = fill_q;
  assign sum_o  = sum_q;

  // Ring write, running-sum update and fill tracking; flush wins over push.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_q   <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wr_q   <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (push_i) begin
      ring_q[wr_q] <= p_i;
      sum_q        <= sum_q + SUM_W'(p_i) - SUM_W'(ring_q[wr_q]);
      wr_q         <= (wr_q == IDX_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (!full_o) fill_q <= fill_q + 1'b1;
    end
  end

endmodule

// File: rtl/mirror_zc_conditioner.sv
// Mirror zero-cross conditioner: synchronizes and debounces the comparator,
// emits a one-cycle zc_o per accepted rising edge, measures the mirror period
// and publishes a moving-average period once the edge train is locked.
module mirror_zc_conditioner
  import zc_cond_pkg::*;
#(
  parameter int SYNC_STAGES_P = 2,
  parameter int DEBOUNCE_P    = 8,
  parameter int AVG_LOG2_P    = 2,
  parameter int PERIOD_MIN_P  = 10000,
  parameter int PERIOD_MAX_P  = 40000,
  parameter int FREQ_INIT_P   = 20000
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                zc_raw_i,
  output logic                zc_o,
  output logic [PERIOD_W-1:0] freq_o,
  output logic                freq_valid_o,
  output logic                lock_o,
  output logic                timeout_o
);

  localparam int DEPTH  = 1 << AVG_LOG2_P;
  localparam int FILL_W = AVG_LOG2_P + 1;
  localparam int SUM_W  = PERIOD_W + AVG_LOG2_P;
  localparam int DB_W   = 8;

  // Saturating period-counter increment so a dead mirror never wraps.
  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES_P-1:0] sync_q;
  logic                     zc_s;
  logic                     zc_f_q;
  logic [DB_W-1:0]          db_cnt_q;
  logic [PERIOD_W-1:0]      per_cnt_q;

  logic                     ev_p0;
  logic                     in_rng_p0;
  logic                     tmo_p0;
  logic                     vld_p1;

  zc_state_e                state_q, state_d;
  logic                     push, flush, upd;

  logic [SUM_W-1:0]         avg_sum;
  logic [FILL_W-1:0]        avg_fill;
  logic                     avg_full;
  logic                     near_full;

  assign zc_s = sync_q[SYNC_STAGES_P-1];

  // Metastability synchronizer on the raw comparator.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES_P-2:0], zc_raw_i};
  end

  // Debounce: toggle the filtered level after DEBOUNCE_P consecutive disagreeing samples.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      zc_f_q   <= 1'b0;
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_P)) begin
      zc_f_q   <= ~zc_f_q;
      db_cnt_q <= '0;
    end else if (zc_s != zc_f_q) begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end else begin
      db_cnt_q <= '0;
    end
  end

  // Stage p0: edge event, range check and watchdog on the pre-increment count.
  assign ev_p0     = (db_cnt_q == DB_W'(DEBOUNCE_P)) && !zc_f_q;
  assign in_rng_p0 = (per_cnt_q >= PERIOD_W'(PERIOD_MIN_P)) &&
                     (per_cnt_q <= PERIOD_W'(PERIOD_MAX_P));
  assign tmo_p0    = (state_q != SEARCH) && !ev_p0 &&
                     (per_cnt_q == PERIOD_W'(PERIOD_MAX_P + 1));
  assign near_full = (avg_fill == FILL_W'(DEPTH - 1)) && !avg_full;

  // Period counter: restarts at 1 on each edge so its value on the next edge is the period.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)    per_cnt_q <= '0;
    else if (ev_p0) per_cnt_q <= PERIOD_W'(1);
    else            per_cnt_q <= sat_inc(per_cnt_q);
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  // FSM next-state logic; watchdog and edge are mutually exclusive by construction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (ev_p0) state_d = ACQUIRE;
      ACQUIRE: begin
        if (tmo_p0)                            state_d = SEARCH;
        else if (ev_p0 && in_rng_p0 && near_full) state_d = LOCKED;
      end
      LOCKED: begin
        if (tmo_p0)                   state_d = SEARCH;
        else if (ev_p0 && !in_rng_p0) state_d = ACQUIRE;
      end
      default: state_d = SEARCH;
    endcase
  end

  // FSM outputs: averager push/flush and the request to republish freq_o.
  always_comb begin
    push  = 1'b0;
    flush = 1'b0;
    upd   = 1'b0;
    case (state_q)
      ACQUIRE: begin
        if (tmo_p0) flush = 1'b1;
        else if (ev_p0) begin
          if (in_rng_p0) begin
            push = 1'b1;
            upd  = near_full;
          end else begin
            flush = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (tmo_p0) flush = 1'b1;
        else if (ev_p0) begin
          if (in_rng_p0) begin
            push = 1'b1;
            upd  = 1'b1;
          end else begin
            flush = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  period_avg #(
    .AVG_LOG2_P (AVG_LOG2_P)
  ) u_avg (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (push),
    .flush_i (flush),
    .p_i     (per_cnt_q),
    .sum_o   (avg_sum),
    .fill_o  (avg_fill),
    .full_o  (avg_full)
  );

  // Stage p1: edge pulse, watchdog pulse and pending average update.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      zc_o      <= 1'b0;
      timeout_o <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      zc_o      <= ev_p0;
      timeout_o <= tmo_p0;
      vld_p1    <= upd;
    end
  end

  // Stage p2: publish the average once the ring sum has absorbed the new period.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      freq_o       <= PERIOD_W'(FREQ_INIT_P);
      freq_valid_o <= 1'b0;
    end else begin
      freq_valid_o <= vld_p1;
      if (vld_p1) freq_o <= PERIOD_W'(avg_sum >> AVG_LOG2_P);
    end
  end

  // Lock flag: rises with the first published average, drops as soon as LOCKED is left.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)                                      lock_o <= 1'b0;
    else if (state_q == LOCKED && state_d != LOCKED)  lock_o <= 1'b0;
    else if (vld_p1 && state_q == LOCKED)             lock_o <= 1'b1;
  end

endmodule

// File: tb/tb_mirror_zc_conditioner.sv
// Directed bench for mirror_zc_conditioner with periods scaled down by 100
// (range 100..400 ticks, initial frequency 200) to keep runs short.
`timescale 1ns/1ps
module tb_mirror_zc_conditioner;
  import zc_cond_pkg::*;

  logic                clk = 1'b0;
  logic                nrst_i;
  logic                zc_raw_i;
  logic                zc_o;
  logic [PERIOD_W-1:0] freq_o;
  logic                freq_valid_o;
  logic                lock_o;
  logic                timeout_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;
  int r0;

  int zc_q[$];
  int fv_q[$];
  int lk_q[$];
  int to_q[$];

  mirror_zc_conditioner #(
    .SYNC_STAGES_P (2),
    .DEBOUNCE_P    (8),
    .AVG_LOG2_P    (2),
    .PERIOD_MIN_P  (100),
    .PERIOD_MAX_P  (400),
    .FREQ_INIT_P   (200)
  ) dut (
    .clk_i        (clk),
    .nrst_i       (nrst_i),
    .zc_raw_i     (zc_raw_i),
    .zc_o         (zc_o),
    .freq_o       (freq_o),
    .freq_valid_o (freq_valid_o),
    .lock_o       (lock_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record output events away from the active edge.
  always @(negedge clk) begin
    if (nrst_i) begin
      if (zc_o) zc_q.push_back(cyc);
      if (freq_valid_o) begin
        fv_q.push_back(int'(freq_o));
        lk_q.push_back(int'(lock_o));
      end
      if (timeout_o) to_q.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    zc_q.delete();
    fv_q.delete();
    lk_q.delete();
    to_q.delete();
  endtask

  // One mirror period: rise at i=0, high for 'high' cycles; optional rising-edge bounce.
  task automatic drive_wave(input int per, input int high, input bit bounce);
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      if (i == 0) last_rise = cyc;
      if (bounce && i < 5) zc_raw_i = (i == 0 || i == 2);
      else                 zc_raw_i = (i < high);
    end
  endtask

  initial begin
    nrst_i   = 1'b0;
    zc_raw_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_zc",    zc_o, 0);
    check_val("rst_freq",  freq_o, 200);
    check_val("rst_fv",    freq_valid_o, 0);
    check_val("rst_lock",  lock_o, 0);
    check_val("rst_tmo",   timeout_o, 0);
    nrst_i = 1'b1;

    // Clean 200-tick square wave: lock on the 5th edge.
    clear_q();
    drive_wave(200, 100, 1'b0);
    r0 = last_rise;
    repeat (4) drive_wave(200, 100, 1'b0);
    check_val("a_zc_cnt",  zc_q.size(), 5);
    check_val("a_latency", (zc_q.size() > 0) ? zc_q[0] - r0 : -1, 11);
    check_val("a_span",    (zc_q.size() == 5) ? zc_q[4] - zc_q[0] : -1, 800);
    check_val("a_fv_cnt",  fv_q.size(), 1);
    check_val("a_fv_val",  (fv_q.size() > 0) ? fv_q[0] : -1, 200);
    check_val("a_fv_lock", (lk_q.size() > 0) ? lk_q[0] : -1, 1);
    check_val("a_lock",    lock_o, 1);

    // Locked averaging: periods 200,200,240,240.
    clear_q();
    drive_wave(200, 100, 1'b0);
    drive_wave(240, 120, 1'b0);
    drive_wave(240, 120, 1'b0);
    drive_wave(400, 200, 1'b0);
    check_val("b_fv_cnt",  fv_q.size(), 4);
    check_val("b_fv0",     (fv_q.size() > 0) ? fv_q[0] : -1, 200);
    check_val("b_fv1",     (fv_q.size() > 1) ? fv_q[1] : -1, 200);
    check_val("b_fv2",     (fv_q.size() > 2) ? fv_q[2] : -1, 210);
    check_val("b_fv3",     (fv_q.size() > 3) ? fv_q[3] : -1, 220);
    check_val("b_lock",    lock_o, 1);

    // Period of exactly PERIOD_MAX accepted, then a 50-tick period breaks lock.
    clear_q();
    drive_wave(50, 25, 1'b0);
    drive_wave(240, 120, 1'b0);
    check_val("c_fv_cnt",  fv_q.size(), 1);
    check_val("c_fv_max",  (fv_q.size() > 0) ? fv_q[0] : -1, 270);
    check_val("c_lock",    lock_o, 0);
    check_val("c_hold",    freq_o, 270);
    check_val("c_zc_cnt",  zc_q.size(), 2);

    // Relock after four 240-tick periods, then the input stalls low.
    clear_q();
    repeat (3) drive_wave(240, 120, 1'b0);
    drive_wave(700, 100, 1'b0);
    check_val("d_zc_cnt",  zc_q.size(), 4);
    check_val("d_fv_cnt",  fv_q.size(), 1);
    check_val("d_fv_val",  (fv_q.size() > 0) ? fv_q[0] : -1, 240);
    check_val("d_fv_lock", (lk_q.size() > 0) ? lk_q[0] : -1, 1);
    check_val("d_tmo_cnt", to_q.size(), 1);
    check_val("d_tmo_dly", (to_q.size() > 0 && zc_q.size() > 0) ?
                           to_q[0] - zc_q[zc_q.size()-1] : -1, 401);
    check_val("d_lock",    lock_o, 0);
    check_val("d_hold",    freq_o, 240);

    // Async reset while acquiring.
    clear_q();
    drive_wave(200, 100, 1'b0);
    drive_wave(200, 100, 1'b0);
    check_val("g_pre_freq", freq_o, 240);
    #2 nrst_i = 1'b0;
    #1;
    check_val("g_freq",    freq_o, 200);
    check_val("g_lock",    lock_o, 0);
    check_val("g_zc",      zc_o, 0);
    check_val("g_fv",      freq_valid_o, 0);
    check_val("g_tmo",     timeout_o, 0);
    repeat (3) @(negedge clk);
    nrst_i = 1'b1;

    // Bouncy rising edges: same period, constant extra latency, no extra pulses.
    clear_q();
    drive_wave(200, 100, 1'b1);
    r0 = last_rise;
    repeat (4) drive_wave(200, 100, 1'b1);
    check_val("f_zc_cnt",  zc_q.size(), 5);
    check_val("f_latency", (zc_q.size() > 0) ? zc_q[0] - r0 : -1, 16);
    check_val("f_span",    (zc_q.size() == 5) ? zc_q[4] - zc_q[0] : -1, 800);
    check_val("f_fv_cnt",  fv_q.size(), 1);
    check_val("f_fv_val",  (fv_q.size() > 0) ? fv_q[0] : -1, 200);
    check_val("f_lock",    lock_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mirror_zc_conditioner.md
# mirror_zc_conditioner

Upstream conditioner for the laser synchronizer. It turns the raw, asynchronous mirror zero-cross comparator signal into a clean one-cycle `zc` pulse. It also measures the mirror period in `clk_i` ticks and publishes a moving-average period that drives the synchronizer's `freq_i` (full mirror period, in ticks). Lock and timeout supervision tell the top level when the timing core may be trusted.

## Interface
- `SYNC_STAGES_P`, 2: synchronizer flops on `zc_raw_i` (2 or 3).
- `DEBOUNCE_P`, 8: consecutive stable synchronized samples needed to accept a level change (1-255).
- `AVG_LOG2_P`, 2: moving-average depth is 2^AVG_LOG2_P periods (0-4).
- `PERIOD_MIN_P`, 10000: smallest in-range period, in ticks.
- `PERIOD_MAX_P`, 40000: largest in-range period, in ticks.
- `FREQ_INIT_P`, 20000: `freq_o` value after reset (25 kHz mirror at 500 MHz).

Ports:
- `clk_i`, in, 1: system clock.
- `nrst_i`, in, 1: asynchronous active-low reset.
- `zc_raw_i`, in, 1: comparator output, asynchronous and possibly bouncing.
- `zc_o`, out, 1: one-cycle pulse on each accepted rising edge.
- `freq_o`, out, 24: averaged mirror period in ticks.
- `freq_valid_o`, out, 1: one-cycle pulse when `freq_o` is updated.
- `lock_o`, out, 1: high while in LOCKED.
- `timeout_o`, out, 1: one-cycle pulse when the edge watchdog fires.

## Operation
- Synchronizer: `SYNC_STAGES_P` flops. The last stage is `zc_s`.
- Debounce:
  - Filtered level `zc_f` resets to 0.
  - A counter increments while `zc_s != zc_f` and clears when they are equal.
  - When the counter reaches `DEBOUNCE_P`, `zc_f` toggles and the counter clears.
  - A 0->1 toggle is an edge event `ev`, registered to `zc_o`.
- Period counter, 24 bits:
  - Cleared to 1 on `ev`, otherwise incremented; saturates at 2^24-1.
  - On `ev`, the measured period `p` equals the counter value. Pulses at cycles 0 and 20000 give p=20000.
  - `p` is in range iff `PERIOD_MIN_P <= p <= PERIOD_MAX_P`.
- Averager: a ring of 2^AVG_LOG2_P entries, a fill count, and a running sum of 24+AVG_LOG2_P bits.
  - Push: sum += p - oldest.
  - `freq_o` = sum >> AVG_LOG2_P.
  - Flush: clears entries, sum and fill count.
- FSM states are SEARCH, ACQUIRE and LOCKED. Reset state is SEARCH.
  - SEARCH -> ACQUIRE on `ev`. No period is measured on this edge.
  - ACQUIRE, `ev` with `p` in range: push. When fill reaches 2^AVG_LOG2_P, go to LOCKED, update `freq_o` and pulse `freq_valid_o`.
  - ACQUIRE, `ev` with `p` out of range: flush and stay in ACQUIRE. This edge becomes the new reference.
  - LOCKED, `ev` with `p` in range: push, update `freq_o`, pulse `freq_valid_o`.
  - LOCKED, `ev` with `p` out of range: flush and go to ACQUIRE. `freq_o` holds its value.
  - ACQUIRE or LOCKED, counter reaches `PERIOD_MAX_P`+1 with no `ev`: pulse `timeout_o`, flush, go to SEARCH. `freq_o` holds.
- `zc_o` is forwarded in every state. The timing core keeps running while unlocked.
- Simultaneous events:
  - `ev` and the counter at exactly `PERIOD_MAX_P` in the same cycle: the edge wins, and the period is in range.
  - The timeout check uses the pre-increment value, so the timeout and `ev` are mutually exclusive.
- Reset mid-operation (async): every register returns to its reset value immediately, and no output glitches past the reset edge.

## Timing
- Reset values:
  - `zc_o`, `freq_valid_o`, `lock_o`, `timeout_o` = 0.
  - `freq_o` = `FREQ_INIT_P`.
  - Internal: `zc_f` = 0, counters = 0, ring flushed.
- Edge latency: the raw input rises and stays stable; `zc_o` pulses `SYNC_STAGES_P`+`DEBOUNCE_P`+1 clocks after the first sampling edge. It is a fixed offset, so it does not bias `p`.
- `freq_o` and `freq_valid_o` update 1 clock after `zc_o` (one pipeline stage for the subtract/add).
- `lock_o` rises in the same cycle as the first `freq_valid_o` of a lock. It falls on the clock after the offending `ev` or the timeout.
- Bounces shorter than `DEBOUNCE_P` cycles are invisible.

## Structure
- Package `zc_cond_pkg`:
  - State enum (SEARCH=2'b00, ACQUIRE=2'b01, LOCKED=2'b10).
  - `PERIOD_W`=24.
- Sub-module `period_avg`: ring, sum, fill count, `push`/`flush`/`full` interface. The FSM, synchronizer, debounce and watchdog stay in the top module.

## Test plan
- Clean square wave with period 20000 and DEBOUNCE_P=8 -> `zc_o` every 20000 clocks, `lock_o` after the 5th edge, `freq_o`=20000.
- Each rising edge followed by 5-cycle bounce glitches -> no extra `zc_o`, period still 20000.
- Locked at 20000, then periods of 20000, 20000, 24000, 24000 -> `freq_o` = 20000, 20000, 21000, 22000.
- Locked, then one period of 5000 -> `lock_o` drops, `freq_o` holds 20000, relock after 4 good periods.
- Input stuck low after lock -> `timeout_o` pulses exactly 40001 clocks after the last `zc_o`, state SEARCH, `freq_o` holds.
- Assert `nrst_i` mid-ACQUIRE -> all outputs return to reset values at once, `freq_o`=20000.
